// File: rtl/simd_permutation_pkg.sv
// Shared types for the SIMD permutation unit: element count, index width,
// per-element index type and the permutation mode encoding.
package simd_permutation_pkg;

    localparam int NumInOuts = 64;
    localparam int IdxW      = 6;

    typedef logic [IdxW-1:0] idx_t;

    typedef enum logic [2:0] {
        GATHER    = 3'd0,
        REVERSE   = 3'd1,
        TRANSPOSE = 3'd2,
        ROT       = 3'd3,
        BANK_ROT  = 3'd4,
        BCAST     = 3'd5,
        SWAP      = 3'd6,
        IDENT     = 3'd7
    } mode_e;

endpackage

// File: rtl/simd_perm_xbar.sv
// Combinational 64x64:1 element selector. Output element e takes the input
// element named by the e-th source index in src_flat.
module simd_perm_xbar
    import simd_permutation_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [NumInOuts*XLEN-1:0] in_flat,
    input  logic [NumInOuts*IdxW-1:0] src_flat,
    output logic [NumInOuts*XLEN-1:0] out_flat
);

    // each output element is a 64:1 mux steered by its own source index
    always_comb begin
        out_flat = '0;
        for (int e = 0; e < NumInOuts; e++) begin
            out_flat[e*XLEN +: XLEN] = in_flat[int'(src_flat[e*IdxW +: IdxW])*XLEN +: XLEN];
        end
    end

endmodule

// File: rtl/simd_permutation.sv
// Streaming SIMD permutation unit: 64 elements (8 banks x 8 lanes) per beat.
// A beat is either an index-table load or a data vector; data vectors are
// permuted by a fixed mode or by the programmable index table.
// Optional macro SIMD_PERM_ASSERT_EN enables SVA checks (datapath unchanged).
module simd_permutation
    import simd_permutation_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int DataWidth        = 16,
    parameter int NumLanes         = 8,
    parameter int NumBanks         = 8,
    parameter int NumSegments      = 8,
    parameter int NumRotationRadix = 4,
    parameter int SizeXbar         = 32,
    parameter int UsePipeline      = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_inValid,
    output logic                         io_inReady,
    input  logic                         io_selIdxVal,
    input  logic [XLEN-1:0]              io_inData_0_0, io_inData_0_1, io_inData_0_2, io_inData_0_3, io_inData_0_4, io_inData_0_5, io_inData_0_6, io_inData_0_7,
    input  logic [XLEN-1:0]              io_inData_1_0, io_inData_1_1, io_inData_1_2, io_inData_1_3, io_inData_1_4, io_inData_1_5, io_inData_1_6, io_inData_1_7,
    input  logic [XLEN-1:0]              io_inData_2_0, io_inData_2_1, io_inData_2_2, io_inData_2_3, io_inData_2_4, io_inData_2_5, io_inData_2_6, io_inData_2_7,
    input  logic [XLEN-1:0]              io_inData_3_0, io_inData_3_1, io_inData_3_2, io_inData_3_3, io_inData_3_4, io_inData_3_5, io_inData_3_6, io_inData_3_7,
    input  logic [XLEN-1:0]              io_inData_4_0, io_inData_4_1, io_inData_4_2, io_inData_4_3, io_inData_4_4, io_inData_4_5, io_inData_4_6, io_inData_4_7,
    input  logic [XLEN-1:0]              io_inData_5_0, io_inData_5_1, io_inData_5_2, io_inData_5_3, io_inData_5_4, io_inData_5_5, io_inData_5_6, io_inData_5_7,
    input  logic [XLEN-1:0]              io_inData_6_0, io_inData_6_1, io_inData_6_2, io_inData_6_3, io_inData_6_4, io_inData_6_5, io_inData_6_6, io_inData_6_7,
    input  logic [XLEN-1:0]              io_inData_7_0, io_inData_7_1, io_inData_7_2, io_inData_7_3, io_inData_7_4, io_inData_7_5, io_inData_7_6, io_inData_7_7,
    input  logic                         io_permute,
    input  logic [2:0]                   io_mode,
    input  logic [DataWidth-1:0]         io_mask_idx_bit,
    input  logic [$clog2(DataWidth)-1:0] io_rshift_idx_bit,
    input  logic                         io_outReady,
    output logic                         io_outValid,
    output logic [XLEN-1:0]              io_outData_0_0, io_outData_0_1, io_outData_0_2, io_outData_0_3, io_outData_0_4, io_outData_0_5, io_outData_0_6, io_outData_0_7,
    output logic [XLEN-1:0]              io_outData_1_0, io_outData_1_1, io_outData_1_2, io_outData_1_3, io_outData_1_4, io_outData_1_5, io_outData_1_6, io_outData_1_7,
    output logic [XLEN-1:0]              io_outData_2_0, io_outData_2_1, io_outData_2_2, io_outData_2_3, io_outData_2_4, io_outData_2_5, io_outData_2_6, io_outData_2_7,
    output logic [XLEN-1:0]              io_outData_3_0, io_outData_3_1, io_outData_3_2, io_outData_3_3, io_outData_3_4, io_outData_3_5, io_outData_3_6, io_outData_3_7,
    output logic [XLEN-1:0]              io_outData_4_0, io_outData_4_1, io_outData_4_2, io_outData_4_3, io_outData_4_4, io_outData_4_5, io_outData_4_6, io_outData_4_7,
    output logic [XLEN-1:0]              io_outData_5_0, io_outData_5_1, io_outData_5_2, io_outData_5_3, io_outData_5_4, io_outData_5_5, io_outData_5_6, io_outData_5_7,
    output logic [XLEN-1:0]              io_outData_6_0, io_outData_6_1, io_outData_6_2, io_outData_6_3, io_outData_6_4, io_outData_6_5, io_outData_6_6, io_outData_6_7,
    output logic [XLEN-1:0]              io_outData_7_0, io_outData_7_1, io_outData_7_2, io_outData_7_3, io_outData_7_4, io_outData_7_5, io_outData_7_6, io_outData_7_7
);

    localparam int ShW = $clog2(DataWidth);

    // The flat port list only exists for an 8x8 arrangement; the reserved
    // knobs must still be sane values.
    if (NumLanes != 8 || NumBanks != 8 || NumSegments < 1 || NumRotationRadix < 1 || SizeXbar < 1) begin : g_bad_cfg
        $error("simd_permutation: port list is fixed at 8 banks x 8 lanes");
    end

    logic [NumInOuts*XLEN-1:0] in_flat;
    logic [NumInOuts*XLEN-1:0] perm_flat;
    logic [NumInOuts*XLEN-1:0] out_flat;
    logic [NumInOuts*IdxW-1:0] src_flat;
    idx_t                      idx_q [NumInOuts];
    logic                      data_ready;
    logic                      load_acc;
    logic                      data_acc;

    // element e = b*8+l sits at slice e of the flat vectors
    assign in_flat = {
        io_inData_7_7, io_inData_7_6, io_inData_7_5, io_inData_7_4, io_inData_7_3, io_inData_7_2, io_inData_7_1, io_inData_7_0,
        io_inData_6_7, io_inData_6_6, io_inData_6_5, io_inData_6_4, io_inData_6_3, io_inData_6_2, io_inData_6_1, io_inData_6_0,
        io_inData_5_7, io_inData_5_6, io_inData_5_5, io_inData_5_4, io_inData_5_3, io_inData_5_2, io_inData_5_1, io_inData_5_0,
        io_inData_4_7, io_inData_4_6, io_inData_4_5, io_inData_4_4, io_inData_4_3, io_inData_4_2, io_inData_4_1, io_inData_4_0,
        io_inData_3_7, io_inData_3_6, io_inData_3_5, io_inData_3_4, io_inData_3_3, io_inData_3_2, io_inData_3_1, io_inData_3_0,
        io_inData_2_7, io_inData_2_6, io_inData_2_5, io_inData_2_4, io_inData_2_3, io_inData_2_2, io_inData_2_1, io_inData_2_0,
        io_inData_1_7, io_inData_1_6, io_inData_1_5, io_inData_1_4, io_inData_1_3, io_inData_1_2, io_inData_1_1, io_inData_1_0,
        io_inData_0_7, io_inData_0_6, io_inData_0_5, io_inData_0_4, io_inData_0_3, io_inData_0_2, io_inData_0_1, io_inData_0_0};

    assign {
        io_outData_7_7, io_outData_7_6, io_outData_7_5, io_outData_7_4, io_outData_7_3, io_outData_7_2, io_outData_7_1, io_outData_7_0,
        io_outData_6_7, io_outData_6_6, io_outData_6_5, io_outData_6_4, io_outData_6_3, io_outData_6_2, io_outData_6_1, io_outData_6_0,
        io_outData_5_7, io_outData_5_6, io_outData_5_5, io_outData_5_4, io_outData_5_3, io_outData_5_2, io_outData_5_1, io_outData_5_0,
        io_outData_4_7, io_outData_4_6, io_outData_4_5, io_outData_4_4, io_outData_4_3, io_outData_4_2, io_outData_4_1, io_outData_4_0,
        io_outData_3_7, io_outData_3_6, io_outData_3_5, io_outData_3_4, io_outData_3_3, io_outData_3_2, io_outData_3_1, io_outData_3_0,
        io_outData_2_7, io_outData_2_6, io_outData_2_5, io_outData_2_4, io_outData_2_3, io_outData_2_2, io_outData_2_1, io_outData_2_0,
        io_outData_1_7, io_outData_1_6, io_outData_1_5, io_outData_1_4, io_outData_1_3, io_outData_1_2, io_outData_1_1, io_outData_1_0,
        io_outData_0_7, io_outData_0_6, io_outData_0_5, io_outData_0_4, io_outData_0_3, io_outData_0_2, io_outData_0_1, io_outData_0_0} = out_flat;

    // Index field of a load beat: shift, mask, keep the low IdxW bits.
    function automatic idx_t idx_extract(input logic [DataWidth-1:0] v,
                                         input logic [ShW-1:0] sh,
                                         input logic [DataWidth-1:0] m);
        return idx_t'((v >> sh) & m);
    endfunction

    // Source element for output e; all index arithmetic wraps naturally
    // in 6 bits (global) or 3 bits (within a bank).
    function automatic idx_t src_of(input idx_t e, input logic perm, input mode_e m,
                                    input idx_t own, input idx_t base);
        idx_t s;
        s = e;
        if (perm) begin
            case (m)
                GATHER:    s = own;
                REVERSE:   s = ~e;
                TRANSPOSE: s = {e[2:0], e[5:3]};
                ROT:       s = e + base;
                BANK_ROT:  s = {e[5:3], e[2:0] + base[2:0]};
                BCAST:     s = base;
                SWAP:      s = e ^ idx_t'(1);
                default:   s = e;
            endcase
        end
        return s;
    endfunction

    // Index loads are always accepted; data beats obey output flow control.
    assign io_inReady = io_selIdxVal ? 1'b1 : data_ready;
    assign load_acc   = io_inValid && io_selIdxVal;
    assign data_acc   = io_inValid && !io_selIdxVal && data_ready;

    // index table: identity after reset, rewritten as a whole by a load beat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < NumInOuts; e++) idx_q[e] <= idx_t'(e);
        end else if (load_acc) begin
            for (int e = 0; e < NumInOuts; e++)
                idx_q[e] <= idx_extract(in_flat[e*XLEN +: DataWidth], io_rshift_idx_bit, io_mask_idx_bit);
        end
    end

    // per-output source index for the mode presented this cycle
    always_comb begin
        src_flat = '0;
        for (int e = 0; e < NumInOuts; e++)
            src_flat[e*IdxW +: IdxW] = src_of(idx_t'(e), io_permute, mode_e'(io_mode), idx_q[e], idx_q[0]);
    end

    simd_perm_xbar #(.XLEN(XLEN)) u_xbar (
        .in_flat  (in_flat),
        .src_flat (src_flat),
        .out_flat (perm_flat)
    );

    if (UsePipeline != 0) begin : g_pipe
        logic                      vld_p1;
        logic [NumInOuts*XLEN-1:0] data_p1;

        // ---- stage p1: single output register, held while stalled ----
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
            end else if (data_acc) begin
                vld_p1  <= 1'b1;
                data_p1 <= perm_flat;
            end else if (io_outReady) begin
                vld_p1  <= 1'b0;
            end
        end

        assign data_ready  = !vld_p1 || io_outReady;
        assign io_outValid = vld_p1;
        assign out_flat    = data_p1;
    end else begin : g_comb
        assign data_ready  = io_outReady;
        assign io_outValid = io_inValid && !io_selIdxVal;
        assign out_flat    = perm_flat;
    end

`ifdef SIMD_PERM_ASSERT_EN
    if (UsePipeline != 0) begin : g_sva_pipe
        a_hold_stable: assert property (@(posedge clock) disable iff (!reset)
            (io_outValid && !io_outReady) |=> (io_outValid && $stable(out_flat)));
        a_no_vld_in_rst: assert property (@(posedge clock) !reset |-> !io_outValid);
    end
    a_idx_ready: assert property (@(posedge clock) disable iff (!reset)
        (io_inValid && io_selIdxVal) |-> io_inReady);
`else
    // checks compiled out; datapath is identical either way
`endif

endmodule

// File: tb/tb_simd_permutation.sv
// Directed bench for simd_permutation: table of single-beat vectors with
// hand-computed sample outputs, plus reset, backpressure and mid-stall reset.
module tb_simd_permutation;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_inValid, io_selIdxVal, io_permute, io_outReady;
    logic        io_inReady, io_outValid;
    logic [2:0]  io_mode;
    logic [15:0] io_mask_idx_bit;
    logic [3:0]  io_rshift_idx_bit;
    logic [63:0] din  [64];
    logic [63:0] dout [64];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    simd_permutation dut (
        .clock(clk), .reset(reset), .io_inValid(io_inValid), .io_inReady(io_inReady),
        .io_selIdxVal(io_selIdxVal), .io_permute(io_permute), .io_mode(io_mode),
        .io_mask_idx_bit(io_mask_idx_bit), .io_rshift_idx_bit(io_rshift_idx_bit),
        .io_outReady(io_outReady), .io_outValid(io_outValid),
        .io_inData_0_0(din[0]),  .io_inData_0_1(din[1]),  .io_inData_0_2(din[2]),  .io_inData_0_3(din[3]),
        .io_inData_0_4(din[4]),  .io_inData_0_5(din[5]),  .io_inData_0_6(din[6]),  .io_inData_0_7(din[7]),
        .io_inData_1_0(din[8]),  .io_inData_1_1(din[9]),  .io_inData_1_2(din[10]), .io_inData_1_3(din[11]),
        .io_inData_1_4(din[12]), .io_inData_1_5(din[13]), .io_inData_1_6(din[14]), .io_inData_1_7(din[15]),
        .io_inData_2_0(din[16]), .io_inData_2_1(din[17]), .io_inData_2_2(din[18]), .io_inData_2_3(din[19]),
        .io_inData_2_4(din[20]), .io_inData_2_5(din[21]), .io_inData_2_6(din[22]), .io_inData_2_7(din[23]),
        .io_inData_3_0(din[24]), .io_inData_3_1(din[25]), .io_inData_3_2(din[26]), .io_inData_3_3(din[27]),
        .io_inData_3_4(din[28]), .io_inData_3_5(din[29]), .io_inData_3_6(din[30]), .io_inData_3_7(din[31]),
        .io_inData_4_0(din[32]), .io_inData_4_1(din[33]), .io_inData_4_2(din[34]), .io_inData_4_3(din[35]),
        .io_inData_4_4(din[36]), .io_inData_4_5(din[37]), .io_inData_4_6(din[38]), .io_inData_4_7(din[39]),
        .io_inData_5_0(din[40]), .io_inData_5_1(din[41]), .io_inData_5_2(din[42]), .io_inData_5_3(din[43]),
        .io_inData_5_4(din[44]), .io_inData_5_5(din[45]), .io_inData_5_6(din[46]), .io_inData_5_7(din[47]),
        .io_inData_6_0(din[48]), .io_inData_6_1(din[49]), .io_inData_6_2(din[50]), .io_inData_6_3(din[51]),
        .io_inData_6_4(din[52]), .io_inData_6_5(din[53]), .io_inData_6_6(din[54]), .io_inData_6_7(din[55]),
        .io_inData_7_0(din[56]), .io_inData_7_1(din[57]), .io_inData_7_2(din[58]), .io_inData_7_3(din[59]),
        .io_inData_7_4(din[60]), .io_inData_7_5(din[61]), .io_inData_7_6(din[62]), .io_inData_7_7(din[63]),
        .io_outData_0_0(dout[0]),  .io_outData_0_1(dout[1]),  .io_outData_0_2(dout[2]),  .io_outData_0_3(dout[3]),
        .io_outData_0_4(dout[4]),  .io_outData_0_5(dout[5]),  .io_outData_0_6(dout[6]),  .io_outData_0_7(dout[7]),
        .io_outData_1_0(dout[8]),  .io_outData_1_1(dout[9]),  .io_outData_1_2(dout[10]), .io_outData_1_3(dout[11]),
        .io_outData_1_4(dout[12]), .io_outData_1_5(dout[13]), .io_outData_1_6(dout[14]), .io_outData_1_7(dout[15]),
        .io_outData_2_0(dout[16]), .io_outData_2_1(dout[17]), .io_outData_2_2(dout[18]), .io_outData_2_3(dout[19]),
        .io_outData_2_4(dout[20]), .io_outData_2_5(dout[21]), .io_outData_2_6(dout[22]), .io_outData_2_7(dout[23]),
        .io_outData_3_0(dout[24]), .io_outData_3_1(dout[25]), .io_outData_3_2(dout[26]), .io_outData_3_3(dout[27]),
        .io_outData_3_4(dout[28]), .io_outData_3_5(dout[29]), .io_outData_3_6(dout[30]), .io_outData_3_7(dout[31]),
        .io_outData_4_0(dout[32]), .io_outData_4_1(dout[33]), .io_outData_4_2(dout[34]), .io_outData_4_3(dout[35]),
        .io_outData_4_4(dout[36]), .io_outData_4_5(dout[37]), .io_outData_4_6(dout[38]), .io_outData_4_7(dout[39]),
        .io_outData_5_0(dout[40]), .io_outData_5_1(dout[41]), .io_outData_5_2(dout[42]), .io_outData_5_3(dout[43]),
        .io_outData_5_4(dout[44]), .io_outData_5_5(dout[45]), .io_outData_5_6(dout[46]), .io_outData_5_7(dout[47]),
        .io_outData_6_0(dout[48]), .io_outData_6_1(dout[49]), .io_outData_6_2(dout[50]), .io_outData_6_3(dout[51]),
        .io_outData_6_4(dout[52]), .io_outData_6_5(dout[53]), .io_outData_6_6(dout[54]), .io_outData_6_7(dout[55]),
        .io_outData_7_0(dout[56]), .io_outData_7_1(dout[57]), .io_outData_7_2(dout[58]), .io_outData_7_3(dout[59]),
        .io_outData_7_4(dout[60]), .io_outData_7_5(dout[61]), .io_outData_7_6(dout[62]), .io_outData_7_7(dout[63])
    );

    typedef struct {
        bit          sel;
        bit          perm;
        logic [2:0]  mode;
        logic [15:0] mask;
        logic [3:0]  sh;
        int          pat;
        int          c0; logic [63:0] e0;
        int          c1; logic [63:0] e1;
        int          c2; logic [63:0] e2;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    // input patterns: 0 -> e, 1 -> 0x100+e, 2 -> (63-e)<<4
    function automatic logic [63:0] pat(input int p, input int e);
        case (p)
            0:       return 64'(e);
            1:       return 64'(256 + e);
            2:       return 64'((63 - e) << 4);
            default: return 64'd0;
        endcase
    endfunction

    task automatic drive(input bit v, input bit sel, input bit perm, input logic [2:0] mode,
                         input logic [15:0] mask, input logic [3:0] sh, input int p);
        io_inValid        = v;
        io_selIdxVal      = sel;
        io_permute        = perm;
        io_mode           = mode;
        io_mask_idx_bit   = mask;
        io_rshift_idx_bit = sh;
        for (int e = 0; e < 64; e++) din[e] = pat(p, e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          sel perm mode mask    sh pat  c0 e0        c1 e1        c2 e2
        vecs[0]  = '{0, 1, 3'd0, 16'h0,  4'd0, 0,  0, 64'd0,    5, 64'd5,    63, 64'd63};
        vecs[1]  = '{0, 1, 3'd1, 16'h0,  4'd0, 1,  0, 64'h13F,  63, 64'h100, 10, 64'h135};
        vecs[2]  = '{0, 1, 3'd2, 16'h0,  4'd0, 0,  1, 64'd8,    8, 64'd1,    10, 64'd17};
        vecs[3]  = '{0, 1, 3'd6, 16'h0,  4'd0, 0,  0, 64'd1,    1, 64'd0,    63, 64'd62};
        vecs[4]  = '{0, 1, 3'd7, 16'h0,  4'd0, 1,  5, 64'h105,  0, 64'h100,  63, 64'h13F};
        vecs[5]  = '{0, 0, 3'd1, 16'h0,  4'd0, 1,  0, 64'h100,  63, 64'h13F, 7, 64'h107};
        vecs[6]  = '{1, 0, 3'd0, 16'h3F, 4'd4, 2,  0, 64'd0,    0, 64'd0,    0, 64'd0};
        vecs[7]  = '{0, 1, 3'd0, 16'h0,  4'd0, 0,  0, 64'd63,   63, 64'd0,   20, 64'd43};
        vecs[8]  = '{0, 1, 3'd3, 16'h0,  4'd0, 0,  0, 64'd63,   1, 64'd0,    63, 64'd62};
        vecs[9]  = '{0, 1, 3'd4, 16'h0,  4'd0, 0,  0, 64'd7,    9, 64'd8,    63, 64'd62};
        vecs[10] = '{0, 1, 3'd5, 16'h0,  4'd0, 1,  0, 64'h13F,  30, 64'h13F, 63, 64'h13F};
        vecs[11] = '{1, 0, 3'd0, 16'h7,  4'd1, 0,  0, 64'd0,    0, 64'd0,    0, 64'd0};
        vecs[12] = '{0, 1, 3'd0, 16'h0,  4'd0, 1,  0, 64'h100,  5, 64'h102,  63, 64'h107};
        vecs[13] = '{0, 1, 3'd5, 16'h0,  4'd0, 1,  0, 64'h100,  30, 64'h100, 63, 64'h100};

        // reset state
        reset       = 1'b0;
        io_outReady = 1'b1;
        drive(0, 0, 0, 3'd0, 16'h0, 4'd0, 0);
        #12;
        chk("rst_outValid", {63'd0, io_outValid}, 64'd0);
        chk("rst_out0", dout[0], 64'd0);
        chk("rst_out63", dout[63], 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // table-driven single beats
        for (int i = 0; i < NV; i++) begin
            drive(1, vecs[i].sel, vecs[i].perm, vecs[i].mode, vecs[i].mask, vecs[i].sh, vecs[i].pat);
            #1;
            chk($sformatf("vec%0d_inReady", i), {63'd0, io_inReady}, 64'd1);
            @(posedge clk); #1;
            io_inValid = 1'b0;
            if (vecs[i].sel) begin
                chk($sformatf("vec%0d_load_outValid", i), {63'd0, io_outValid}, 64'd0);
            end else begin
                chk($sformatf("vec%0d_outValid", i), {63'd0, io_outValid}, 64'd1);
                chk($sformatf("vec%0d_out%0d", i, vecs[i].c0), dout[vecs[i].c0], vecs[i].e0);
                chk($sformatf("vec%0d_out%0d", i, vecs[i].c1), dout[vecs[i].c1], vecs[i].e1);
                chk($sformatf("vec%0d_out%0d", i, vecs[i].c2), dout[vecs[i].c2], vecs[i].e2);
            end
        end
        @(posedge clk); #1;
        chk("idle_outValid", {63'd0, io_outValid}, 64'd0);

        // backpressure: A held for 3 stalled cycles while B waits
        io_outReady = 1'b0;
        drive(1, 0, 1, 3'd7, 16'h0, 4'd0, 1);
        @(posedge clk); #1;
        drive(1, 0, 1, 3'd1, 16'h0, 4'd0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_inReady", c), {63'd0, io_inReady}, 64'd0);
            chk($sformatf("bp%0d_outValid", c), {63'd0, io_outValid}, 64'd1);
            chk($sformatf("bp%0d_out0", c), dout[0], 64'h100);
            chk($sformatf("bp%0d_out63", c), dout[63], 64'h13F);
            @(posedge clk); #1;
        end
        io_outReady = 1'b1;
        #1;
        chk("bp_release_inReady", {63'd0, io_inReady}, 64'd1);
        @(posedge clk); #1;
        chk("bp_B_outValid", {63'd0, io_outValid}, 64'd1);
        chk("bp_B_out0", dout[0], 64'd63);
        drive(1, 0, 1, 3'd7, 16'h0, 4'd0, 1);
        @(posedge clk); #1;
        io_inValid = 1'b0;
        chk("bp_C_outValid", {63'd0, io_outValid}, 64'd1);
        chk("bp_C_out0", dout[0], 64'h100);
        @(posedge clk); #1;
        chk("bp_drain_outValid", {63'd0, io_outValid}, 64'd0);

        // reset while a vector is held discards it and restores the table
        io_outReady = 1'b0;
        drive(1, 0, 1, 3'd7, 16'h0, 4'd0, 1);
        @(posedge clk); #1;
        io_inValid = 1'b0;
        chk("mid_held_outValid", {63'd0, io_outValid}, 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_outValid", {63'd0, io_outValid}, 64'd0);
        chk("mid_rst_out0", dout[0], 64'd0);
        @(posedge clk); #1;
        reset       = 1'b1;
        io_outReady = 1'b1;
        drive(1, 0, 1, 3'd0, 16'h0, 4'd0, 0);
        @(posedge clk); #1;
        io_inValid = 1'b0;
        chk("mid_gather_out5", dout[5], 64'd5);
        chk("mid_gather_out63", dout[63], 64'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
